// File: rtl/nibble_serial_adder_if.sv
// Purpose: operand/result bundle between a requester and nibble_serial_adder.
// Latency: none (wires only).
// Backpressure: none; requester watches busy/done, start is ignored while busy.
// Ports: master drives start/sub/a/b and observes busy/done/sum/cout/overflow;
//        slave (the adder) is the mirror image.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Purpose: W-bit add/subtract done one 4-bit slice per clock, LSB nibble first.
// Latency: done pulses NIBBLES cycles after start is accepted; one op per NIBBLES+2 cycles.
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, not queued.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//        start/sub/a/b in; busy/done/sum/cout/overflow out, all registered.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input logic                 clk,
   input logic                 reset,
   nibble_serial_adder_if.slave bus
);
   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = $clog2(NIBBLES);
   localparam logic [IDXW-1:0] LASTIDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   stateT           state;
   logic [IDXW-1:0] idx;
   logic [W-1:0]    aReg;
   logic [W-1:0]    bReg;       // already inverted for subtraction
   logic            carryReg;
   logic [W-1:0]    sumReg;
   logic            coutReg;
   logic            ovfReg;
   logic            busyReg;
   logic            doneReg;

   logic [3:0]      aNib;
   logic [3:0]      bNib;
   logic [4:0]      nibRes;
   logic            msbCarryIn;

   // One 4-bit slice of the datapath, fed by the current nibble index.
   always_comb begin
      aNib   = aReg[{idx, 2'b00} +: 4];
      bNib   = bReg[{idx, 2'b00} +: 4];
      nibRes = {1'b0, aNib} + {1'b0, bNib} + {4'b0000, carryReg};
      // Carry into the slice's top bit recovered from a ^ b ^ sum at that bit.
      msbCarryIn = aNib[3] ^ bNib[3] ^ nibRes[3];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         aReg     <= '0;
         bReg     <= '0;
         carryReg <= 1'b0;
         sumReg   <= '0;
         coutReg  <= 1'b0;
         ovfReg   <= 1'b0;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               doneReg <= 1'b0;
               if (bus.start) begin
                  aReg     <= bus.a;
                  // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
                  bReg     <= bus.sub ? ~bus.b : bus.b;
                  carryReg <= bus.sub;
                  idx      <= '0;
                  sumReg   <= '0;
                  coutReg  <= 1'b0;
                  ovfReg   <= 1'b0;
                  busyReg  <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               sumReg[{idx, 2'b00} +: 4] <= nibRes[3:0];
               carryReg                  <= nibRes[4];
               if (idx == LASTIDX) begin
                  coutReg <= nibRes[4];
                  ovfReg  <= msbCarryIn ^ nibRes[4];
                  busyReg <= 1'b0;
                  doneReg <= 1'b1;
                  state   <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               doneReg <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busyReg <= 1'b0;
               doneReg <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.sum      = sumReg;
   assign bus.cout     = coutReg;
   assign bus.overflow = ovfReg;
   assign bus.busy     = busyReg;
   assign bus.done     = doneReg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose: directed and model-based checks of nibble_serial_adder at NIBBLES = 4, 2, 8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_nibble_serial_adder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          sel = 0;          // 0: NIBBLES=4, 1: NIBBLES=2, 2: NIBBLES=8
   logic        startReq = 1'b0;
   logic        subIn = 1'b0;
   logic [63:0] opA = '0;
   logic [63:0] opB = '0;

   nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
   nibble_serial_adder_if #(.NIBBLES(2)) bus2 ();
   nibble_serial_adder_if #(.NIBBLES(8)) bus8 ();

   assign bus4.start = startReq && (sel == 0);
   assign bus4.sub   = subIn;
   assign bus4.a     = opA[15:0];
   assign bus4.b     = opB[15:0];
   assign bus2.start = startReq && (sel == 1);
   assign bus2.sub   = subIn;
   assign bus2.a     = opA[7:0];
   assign bus2.b     = opB[7:0];
   assign bus8.start = startReq && (sel == 2);
   assign bus8.sub   = subIn;
   assign bus8.a     = opA[31:0];
   assign bus8.b     = opB[31:0];

   nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
   nibble_serial_adder #(.NIBBLES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
   nibble_serial_adder #(.NIBBLES(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

   logic        obsBusy, obsDone, obsCout, obsOvf;
   logic [63:0] obsSum;

   always_comb begin
      obsBusy = bus4.busy;
      obsDone = bus4.done;
      obsCout = bus4.cout;
      obsOvf  = bus4.overflow;
      obsSum  = {48'b0, bus4.sum};
      if (sel == 1) begin
         obsBusy = bus2.busy;
         obsDone = bus2.done;
         obsCout = bus2.cout;
         obsOvf  = bus2.overflow;
         obsSum  = {56'b0, bus2.sum};
      end else if (sel == 2) begin
         obsBusy = bus8.busy;
         obsDone = bus8.done;
         obsCout = bus8.cout;
         obsOvf  = bus8.overflow;
         obsSum  = {32'b0, bus8.sum};
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {overflow, cout, sum} for a W-bit add/subtract.
   function automatic logic [65:0] refModel(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input logic sb);
      logic [63:0] mask, bb, full, s;
      logic        c, o;
      mask = (64'd1 << w) - 64'd1;
      bb   = sb ? (~y & mask) : (y & mask);
      full = (x & mask) + bb + {63'b0, sb};
      s    = full & mask;
      c    = full[w];
      o    = (x[w-1] == bb[w-1]) && (s[w-1] != x[w-1]);
      return {o, c, s};
   endfunction

   task automatic runOp(input int s, input logic [63:0] x, input logic [63:0] y, input logic sb,
                        input logic [63:0] eS, input logic eC, input logic eO, input string tag);
      int nib;
      int cyc;
      int busyCnt;
      nib = (s == 0) ? 4 : (s == 1) ? 2 : 8;
      cyc = 0;
      busyCnt = 0;
      sel = s;
      opA = x;
      opB = y;
      subIn = sb;
      startReq = 1'b1;
      tick();
      startReq = 1'b0;
      // Scramble inputs after acceptance: result must come from latched operands.
      opA = ~x;
      opB = ~y;
      subIn = ~sb;
      while (!obsDone && cyc < 40) begin
         if (obsBusy) busyCnt++;
         tick();
         cyc++;
      end
      checkVal({tag, ".lat"}, 64'(cyc), 64'(nib));
      checkVal({tag, ".busy"}, 64'(busyCnt), 64'(nib));
      checkVal({tag, ".sum"}, obsSum, eS);
      checkVal({tag, ".cout"}, {63'b0, obsCout}, {63'b0, eC});
      checkVal({tag, ".ovf"}, {63'b0, obsOvf}, {63'b0, eO});
      tick();
      checkVal({tag, ".doneClr"}, {63'b0, obsDone}, 64'd0);
      checkVal({tag, ".sumHold"}, obsSum, eS);
   endtask

   initial begin
      logic [63:0] x, y, mask;
      logic        sb;
      logic [65:0] r;
      int          w;
      int          doneCnt;

      tick();
      tick();
      reset = 1'b0;
      tick();
      checkVal("rst.sum", {48'b0, bus4.sum}, 64'd0);
      checkVal("rst.flags", {59'b0, bus4.busy, bus4.done, bus4.cout, bus4.overflow, 1'b0}, 64'd0);

      // Directed NIBBLES=4 vectors, expected values worked by hand.
      runOp(0, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0, "add");
      runOp(0, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, "ripple");
      runOp(0, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1, "addOvf");
      runOp(0, 64'h0003, 64'h0005, 1'b1, 64'hFFFE, 1'b0, 1'b0, "subNeg");
      runOp(0, 64'h8000, 64'h0001, 1'b1, 64'h7FFF, 1'b1, 1'b1, "subOvf");

      // Busy lockout: a second start mid-run must be dropped.
      sel = 0;
      opA = 64'h1111; opB = 64'h2222; subIn = 1'b0; startReq = 1'b1;
      tick();                                    // edge k: accepted
      startReq = 1'b0;
      tick();                                    // k+1
      opA = 64'hAAAA; opB = 64'h5555; startReq = 1'b1;
      tick();                                    // k+2: start ignored
      startReq = 1'b0;
      checkVal("lock.busyMid", {63'b0, bus4.busy}, 64'd1);
      tick();                                    // k+3
      checkVal("lock.noEarlyDone", {63'b0, bus4.done}, 64'd0);
      tick();                                    // k+4
      checkVal("lock.done", {63'b0, bus4.done}, 64'd1);
      checkVal("lock.sum", {48'b0, bus4.sum}, 64'h3333);
      // Hold start from DONE: accepted on the first IDLE edge, not in DONE.
      opA = 64'h0001; opB = 64'h0001; startReq = 1'b1;
      tick();                                    // k+5: DONE -> IDLE
      checkVal("hold.idleBusy", {63'b0, bus4.busy}, 64'd0);
      checkVal("hold.idleDone", {63'b0, bus4.done}, 64'd0);
      tick();                                    // k+6: accepted
      checkVal("hold.accepted", {63'b0, bus4.busy}, 64'd1);
      checkVal("hold.sumClr", {48'b0, bus4.sum}, 64'd0);
      startReq = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus4.done) begin
            doneCnt++;
            checkVal("hold.sum", {48'b0, bus4.sum}, 64'h0002);
         end
      end
      checkVal("hold.doneCnt", 64'(doneCnt), 64'd1);

      // Reset at the second RUN edge aborts with no done pulse.
      opA = 64'h00FF; opB = 64'h0001; subIn = 1'b0; startReq = 1'b1;
      tick();                                    // edge k: accepted
      startReq = 1'b0;
      tick();                                    // k+1: first RUN edge
      reset = 1'b1;
      tick();                                    // k+2: reset sampled
      reset = 1'b0;
      checkVal("abort.sum", {48'b0, bus4.sum}, 64'd0);
      checkVal("abort.flags", {60'b0, bus4.busy, bus4.done, bus4.cout, bus4.overflow}, 64'd0);
      doneCnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus4.done) doneCnt++;
      end
      checkVal("abort.noDone", 64'(doneCnt), 64'd0);
      runOp(0, 64'h0001, 64'h0001, 1'b0, 64'h0002, 1'b0, 1'b0, "afterAbort");

      // Width sweep against the reference model.
      for (int s = 1; s <= 2; s++) begin
         w = (s == 1) ? 8 : 32;
         mask = (64'd1 << w) - 64'd1;
         for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
               x = mask; y = 64'd1; sb = 1'b0;
            end else if (i == 1) begin
               x = 64'd1 << (w - 1); y = 64'd1; sb = 1'b1;
            end else begin
               x = {32'b0, $urandom} & mask;
               y = {32'b0, $urandom} & mask;
               sb = 1'($urandom_range(0, 1));
            end
            r = refModel(w, x, y, sb);
            runOp(s, x, y, sb, r[63:0], r[64], r[65], (s == 1) ? "n2" : "n8");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle N-nibble adder/subtractor built around a 4-bit adder slice with a registered carry. It takes wide operands on a start pulse and processes one nibble per clock, LSB first. It reports completion with a one-cycle done pulse. It is the sequencing front end that lets the lab's 4-bit adder datapath handle 16-bit (default) operands for the board-level calculator.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a-b; latched with operands
- a  input  W  operand A; latched on accepted start
- b  input  W  operand B; latched on accepted start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse; result valid
- sum  output  W  result (mod 2^W); holds until next accepted start
- cout  output  1  carry out of MSB nibble (for sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow of the W-bit result

## Operation
- One clock; reset is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at a rising edge, the block latches a into A_reg and (sub ? ~b : b) into B_reg. It sets carry_reg=sub, clears nibble index idx=0, clears sum, and moves to RUN. Otherwise it stays in IDLE.
- RUN, each edge:
  - {c, s4} = A_reg[idx] + B_reg[idx] + carry_reg, in 5-bit arithmetic.
  - sum[4*idx+3:4*idx] <= s4; carry_reg <= c.
  - When idx is the MSB nibble, the block also captures the carry into bit W-1 for overflow.
  - If idx = NIBBLES-1, it moves to DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, then unconditionally returns to IDLE.
- On entering DONE: cout = final carry_reg; overflow = (carry into bit W-1) XOR (carry out of bit W-1).
- Width rules:
  - sum wraps mod 2^W.
  - Subtraction is A + ~B + 1.
  - idx is ceil(log2(NIBBLES)) bits wide and never exceeds NIBBLES-1.
- start in RUN or DONE is ignored and never queued. Operand or sub changes during RUN do not affect the result.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- cout, overflow and sum keep their values after DONE until the next accepted start. At that start they are cleared: sum=0, cout=0, overflow=0.

## Timing
- Reset (at any edge, including mid-RUN or DONE):
  - state=IDLE, idx=0, carry_reg=0.
  - sum=0, cout=0, overflow=0, busy=0, done=0.
  - An aborted operation produces no done pulse.
- Edge k is the edge where start is accepted:
  - busy=1 from after edge k through edge k+NIBBLES.
  - After edge k+NIBBLES: state=DONE, done=1, busy=0, sum/cout/overflow valid.
  - After edge k+NIBBLES+1: state=IDLE, done=0.
- Latency from start acceptance to done: NIBBLES cycles. Throughput: one operation per NIBBLES+2 cycles.
- Nibble j of sum is final after edge k+j+1. Intermediate sum values are not guaranteed meaningful until done.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add: a=0x1234, b=0x4321, sub=0, start one cycle → done exactly 4 cycles after acceptance; sum=0x5555, cout=0, overflow=0; busy high for 4 cycles.
- Carry ripple across all nibbles: 0xFFFF + 0x0001 → sum=0x0000, cout=1, overflow=0; 0x7FFF + 0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtract: 0x0003 - 0x0005 → sum=0xFFFE, cout=0, overflow=0; 0x8000 - 0x0001 → sum=0x7FFF, cout=1, overflow=1.
- Busy lockout: accept 0x1111+0x2222, then pulse start with a=0xAAAA during RUN and change b mid-run → single done, sum=0x3333. With start held high, the next operation is accepted on the edge after DONE.
- Reset mid-operation: assert reset at the second RUN edge of 0x00FF+0x0001 → the next cycle shows all outputs 0 and IDLE, with no done pulse. A fresh 0x0001+0x0001 then yields 0x0002 after 4 cycles.
- Parameter sweep: NIBBLES=2 and 8 with random operands against a reference model (a±b mod 2^W, cout, overflow); latency equals NIBBLES in every case.
